// File: rtl/uart_pkt_router.sv
// UART packet router: two-frame packets (address, data) on one serial line are
// matched against a programmable address table and queued into per-port FWFT FIFOs.
module uart_pkt_router #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8,
    parameter int NUM_PORTS    = 4,
    parameter int FIFO_DEPTH   = 8,
    parameter int PARITY_ODD   = 0,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
    input  logic                          cfg_we,
    input  logic [$clog2(NUM_PORTS)-1:0]  cfg_sel,
    input  logic [DATA_W-1:0]             cfg_addr,
    output logic [NUM_PORTS-1:0]          out_valid,
    input  logic [NUM_PORTS-1:0]          out_ready,
    output logic [NUM_PORTS*DATA_W-1:0]   out_data,
    output logic [NUM_PORTS-1:0]          fifo_full,
    output logic                          err_parity,
    output logic                          err_frame,
    output logic                          err_drop,
    output logic [15:0]                   drop_cnt
);
    localparam int SEL_W     = $clog2(NUM_PORTS);
    localparam int CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int BIT_W     = $clog2(DATA_W + 1);
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W      = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;
    typedef enum logic {WAIT_ADDR, WAIT_DATA} pkt_state_t;

    // Valid/ready: a port entry leaves its FIFO on any cycle where out_valid && out_ready.
    logic rx_s1, rx_s2, rx_prev;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end
    wire fall = rx_prev & ~rx_s2;

    rx_state_t          rx_state, rx_next;
    logic [CNT_W-1:0]   bit_cnt;
    logic [BIT_W-1:0]   bit_idx;
    logic [DATA_W-1:0]  shift;
    logic               par_bit;
    wire half_tick = (bit_cnt == CNT_W'(CLKS_PER_BIT / 2 - 1));
    wire full_tick = (bit_cnt == CNT_W'(CLKS_PER_BIT - 1));
    wire stop_tick = (rx_state == RX_STOP) && full_tick;
    wire par_bad   = (^{shift, par_bit}) != (PARITY_ODD != 0);

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (fall) rx_next = RX_START;
            RX_START: if (half_tick) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (full_tick && bit_idx == BIT_W'(DATA_W - 1)) rx_next = RX_PAR;
            RX_PAR:   if (full_tick) rx_next = RX_STOP;
            RX_STOP:  if (full_tick) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state <= RX_IDLE;
        else        rx_state <= rx_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            par_bit <= 1'b0;
        end else begin
            if (rx_state == RX_IDLE || (rx_state == RX_START && half_tick) || full_tick)
                bit_cnt <= '0;
            else
                bit_cnt <= bit_cnt + 1'b1;
            if (rx_state != RX_DATA)
                bit_idx <= '0;
            else if (full_tick)
                bit_idx <= bit_idx + 1'b1;
            if (rx_state == RX_DATA && full_tick)
                shift <= {rx_s2, shift[DATA_W-1:1]};
            if (rx_state == RX_PAR && full_tick)
                par_bit <= rx_s2;
        end
    end

    // Frame results are registered at the stop-bit sample so everything downstream acts at T+1.
    logic              frame_valid, frame_good;
    logic [DATA_W-1:0] frame_byte;
    logic              timeout;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_valid <= 1'b0;
            frame_good  <= 1'b0;
            frame_byte  <= '0;
            err_parity  <= 1'b0;
            err_frame   <= 1'b0;
        end else begin
            frame_valid <= stop_tick;
            frame_good  <= stop_tick && rx_s2 && !par_bad;
            err_parity  <= stop_tick && rx_s2 && par_bad;
            err_frame   <= (stop_tick && !rx_s2) || timeout;
            if (stop_tick) frame_byte <= shift;
        end
    end

    logic [DATA_W-1:0] addr_tab [NUM_PORTS];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PORTS; i++) addr_tab[i] <= DATA_W'(i);
        end else if (cfg_we && int'(cfg_sel) < NUM_PORTS) begin
            addr_tab[cfg_sel] <= cfg_addr;
        end
    end

    // Scan from the top so the lowest matching index wins on duplicates.
    logic             addr_hit;
    logic [SEL_W-1:0] addr_idx;
    always_comb begin
        addr_hit = 1'b0;
        addr_idx = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (addr_tab[i] == frame_byte) begin
                addr_hit = 1'b1;
                addr_idx = SEL_W'(i);
            end
        end
    end

    pkt_state_t       pkt_state, pkt_next;
    logic             hit_q;
    logic [SEL_W-1:0] port_q;
    logic [TO_W-1:0]  timer;
    logic             push, latch;
    logic [NUM_PORTS-1:0] pop;
    wire push_ok = !fifo_full[port_q] || pop[port_q];

    always_comb begin
        timeout = (TO_CYCLES != 0) && (pkt_state == WAIT_DATA) && (rx_state == RX_IDLE)
                  && !fall && (timer == TO_W'(TO_CYCLES - 1));
    end

    always_comb begin
        pkt_next = pkt_state;
        push     = 1'b0;
        err_drop = 1'b0;
        latch    = 1'b0;
        case (pkt_state)
            WAIT_ADDR: begin
                if (frame_valid && frame_good) begin
                    latch    = 1'b1;
                    pkt_next = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (frame_valid) begin
                    pkt_next = WAIT_ADDR;
                    if (frame_good) begin
                        if (hit_q && push_ok) push = 1'b1;
                        else                  err_drop = 1'b1;
                    end
                end else if (timeout) begin
                    pkt_next = WAIT_ADDR;
                end
            end
            default: pkt_next = WAIT_ADDR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_state <= WAIT_ADDR;
            hit_q     <= 1'b0;
            port_q    <= '0;
            timer     <= '0;
            drop_cnt  <= '0;
        end else begin
            pkt_state <= pkt_next;
            if (latch) begin
                hit_q  <= addr_hit;
                port_q <= addr_idx;
            end
            if (latch || fall || rx_state != RX_IDLE)
                timer <= '0;
            else if (pkt_state == WAIT_DATA)
                timer <= timer + 1'b1;
            if (err_drop && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [DATA_W-1:0] mem [FIFO_DEPTH];
        logic [PTR_W-1:0]  wr_ptr, rd_ptr;
        logic [PTR_W:0]    count;
        wire do_push = push && (port_q == SEL_W'(p));

        assign pop[p] = out_valid[p] && out_ready[p];

        always_ff @(posedge clk) begin
            if (do_push) mem[wr_ptr] <= frame_byte;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + 1'b1;
                if (pop[p])  rd_ptr <= rd_ptr + 1'b1;
                if (do_push && !pop[p])      count <= count + 1'b1;
                else if (!do_push && pop[p]) count <= count - 1'b1;
            end
        end

        assign out_valid[p] = (count != '0);
        assign fifo_full[p] = (count == (PTR_W+1)'(FIFO_DEPTH));
        assign out_data[p*DATA_W +: DATA_W] = out_valid[p] ? mem[rd_ptr] : '0;
    end
endmodule

// File: doc/uart_pkt_router.md
Name: uart_pkt_router

Overview:
- Parametrised successor to the single-channel UART FIFO multiplexer.
- Receives two-frame UART packets (address frame, then data frame) on one serial line.
- Matches the address against a runtime-programmable per-port address table and pushes the data byte into that port's FIFO.
- Each of NUM_PORTS outputs drains through its own valid/ready stream; parity, framing, drop and timeout errors are flagged and counted.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit; even, >=4.
- DATA_W, 8, bits per frame payload; also the address width.
- NUM_PORTS, 4, output channels; 2..8.
- FIFO_DEPTH, 8, entries per port FIFO; power of 2, >=2.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity.
- TIMEOUT_BITS, 32, maximum bit-times from address stop bit to data start bit; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rx  in  1  serial input, idle high, asynchronous to clk.
- cfg_we  in  1  address-table write strobe.
- cfg_sel  in  $clog2(NUM_PORTS)  table entry to write.
- cfg_addr  in  DATA_W  address value to store.
- out_valid  out  NUM_PORTS  per-port FIFO non-empty.
- out_ready  in  NUM_PORTS  per-port consumer ready.
- out_data  out  NUM_PORTS*DATA_W  per-port head entry; port i occupies bits [i*DATA_W +: DATA_W].
- fifo_full  out  NUM_PORTS  per-port FIFO full.
- err_parity  out  1  one-cycle pulse on parity mismatch.
- err_frame  out  1  one-cycle pulse on stop bit = 0 or inter-frame timeout.
- err_drop  out  1  one-cycle pulse when a valid packet is discarded (no match or FIFO full).
- drop_cnt  out  16  saturating count of err_drop pulses.

Behaviour:
- Reset values:
  - all outputs 0;
  - rx synchroniser flops 1;
  - all FIFOs empty;
  - address table entry i = i;
  - packet FSM in WAIT_ADDR.
- rx path: 2-flop synchroniser. The receiver runs on the synchronised value only.
- Receiver FSM (RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP):
  - RX_IDLE -> RX_START on a 1->0 edge.
  - RX_START: resample after CLKS_PER_BIT/2 cycles. If 1, treat as a glitch, return to RX_IDLE, no error.
  - Later samples are taken every CLKS_PER_BIT cycles (bit centres).
  - Frame format: DATA_W data bits LSB-first, then parity, then stop.
  - Parity check: XOR of data bits and parity bit must equal PARITY_ODD.
- Frame completion happens at the stop-bit sample cycle T:
  - stop = 0 -> err_frame pulses at T+1;
  - otherwise a parity mismatch -> err_parity pulses at T+1;
  - if both occur, only err_frame pulses.
- Packet FSM (WAIT_ADDR, WAIT_DATA):
  - Good address frame: compare against all table entries combinationally. The lowest-index match is latched with a match flag; go to WAIT_DATA.
  - Bad address frame: stay in WAIT_ADDR.
  - Good data frame with a match: push to the latched port at T+1. out_valid of that port is high from cycle T+2.
  - Good data frame without a match: no push; err_drop pulses.
  - Bad data frame: no push, no err_drop.
  - Every data frame, good or bad, returns the FSM to WAIT_ADDR.
  - Timeout: in WAIT_DATA, if TIMEOUT_BITS*CLKS_PER_BIT cycles elapse without a start-bit edge, pulse err_frame and return to WAIT_ADDR. The timer restarts at each address-frame completion.
- Full FIFO: the push is allowed if the FIFO is not full, or if that port pops in the same cycle (out_valid&&out_ready). Otherwise the data is discarded and err_drop pulses.
- drop_cnt increments on every err_drop and saturates at 16'hFFFF.
- FIFO behaviour:
  - first-word-fall-through: out_data is the head entry whenever out_valid = 1;
  - pop when out_valid&&out_ready;
  - pointers wrap modulo FIFO_DEPTH;
  - fifo_full reflects the registered count;
  - ports are fully independent.
- Config writes:
  - cfg_we updates the entry on the next edge, at any time;
  - a packet already past address matching keeps its latched port;
  - when duplicate addresses exist, the lowest index wins.
- Reset is asynchronous. Asserting rst_n mid-frame or mid-packet aborts everything immediately: FIFO contents are lost and there is no error pulse.

Test Plan:
- Route: default table, packet addr=8'h02 data=8'hA5, even parity, out_ready=0 -> out_valid=4'b0100, out_data[23:16]=8'hA5, no error pulses; raise out_ready[2] -> out_valid=0 one cycle later.
- Reprogram: cfg_sel=3, cfg_addr=8'h7E, then packet addr=8'h7E data=8'h3C -> port 3 receives 8'h3C. Then packet addr=8'h03 -> err_drop, drop_cnt=1.
- Errors: address frame with flipped parity -> err_parity and no push; the next valid packet routes normally. Data frame with stop=0 -> err_frame and no push.
- Full: FIFO_DEPTH+1 packets to port 0 with out_ready=0 -> fifo_full[0]=1, ninth packet dropped, drop_cnt=1. Repeat with out_ready[0] pulsed exactly at push cycle T+1 -> push accepted, no drop.
- Timeout/glitch: good address frame then rx idle for 33 bit-times -> err_frame, FSM in WAIT_ADDR. A 3-cycle low glitch on rx -> no frame, no error.
- Reset mid-frame: deassert rst_n during data bit 4 with port 1 holding 2 entries -> all outputs 0, FIFOs empty; the next packet is received correctly.
